regfile_dump_reader: RTL
========================

# regfile_dump_reader

Debug read-out engine for the core register file. On a start command it walks a programmable range of register indices through a dedicated register-file read port. Each word is returned on a valid/ready output stream, tagged with its index and a last flag. The block sits between the register file's debug read port and the debug transport; it only reads and never writes the register file.

## Interface
Parameters:
- DATA_W, 32, register word width
- ADDR_W, 5, register index width; range arithmetic is modulo 2^ADDR_W

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  request a dump; sampled only in IDLE
- first_idx  input  ADDR_W  first register index, captured on accepted start
- last_idx  input  ADDR_W  last register index, captured on accepted start
- abort  input  1  cancel dump; priority over start
- rf_raddr  output  ADDR_W  register-file read address
- rf_rdata  input  DATA_W  register-file read data, combinational from rf_raddr
- out_valid  output  1  stream word valid
- out_ready  input  1  downstream accepts word
- out_data  output  DATA_W  register value
- out_index  output  ADDR_W  index of out_data
- out_last  output  1  word is the final one of the dump
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after the last word is accepted
- checksum  output  DATA_W  XOR of all words accepted in the current or most recent dump

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE, start=1, abort=0: capture idx<=first_idx and last<=last_idx, clear checksum, then go to LOAD.
- LOAD: rf_raddr=idx. At the edge, out_data<=rf_rdata and out_index<=idx. out_last<=(idx==last). Go to SEND.
- SEND: out_valid=1. out_data, out_index and out_last are held stable until out_ready=1.
  - On handshake, checksum^=out_data.
  - If out_last, go to DONE.
  - Otherwise idx<=idx+1 (mod 2^ADDR_W, so 31 wraps to 0) and go to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE.
- Word count is ((last_idx-first_idx) mod 2^ADDR_W)+1.
  - first_idx==last_idx gives one word.
  - first_idx>last_idx wraps through the top index.
  - A full 32-word dump uses first=0, last=31, or first=k, last=k-1.
- rf_raddr outside LOAD holds idx; it has no side effects.
- start while busy is ignored and is not queued.
- abort=1 in any non-IDLE state: next edge goes to IDLE.
  - out_valid drops.
  - No done pulse.
  - checksum keeps its partial value.
- abort in IDLE has no effect and suppresses a simultaneous start.
- Index 0 is read like any other index; its value is whatever the register file returns (0 for the RISC-V regfile).

## Timing
- Reset values:
  - State: IDLE.
  - out_valid=0, out_data=0, out_index=0, out_last=0.
  - busy=0, done=0, checksum=0, rf_raddr=0.
- Reset assertion mid-dump returns to IDLE immediately (asynchronous) and drops out_valid combinationally with state.
- Latency: start sampled at edge E0, LOAD during the next cycle, out_valid=1 after E1.
- Throughput: one word per 2 cycles with out_ready held high.
- N-word dump with no backpressure:
  - done is high in the cycle after the edge that accepts the last word.
  - busy is high from E0+ through the DONE cycle, 2N+1 cycles total.
- Handshake: a word transfers on a rising edge with out_valid&out_ready. out_valid never drops without a transfer, except on abort or reset.
- rf_rdata must settle within one cycle of rf_raddr. Register-file writes during a dump are not blocked; the value read is the one present during that word's LOAD cycle.
- checksum is stable and final when done=1 and stays unchanged until the next accepted start.

## Test plan
- Full dump: regs preset to 32'h1000_0000+i, first=0, last=31, out_ready=1.
  - Expect 32 words, index i, data 32'h1000_0000+i, out_last only on index 31.
  - Expect done 65 cycles after start and checksum = XOR of all 32 values.
- Wrap: first=30, last=1.
  - Expect indices 30, 31, 0, 1 in that order, out_last on index 1, 4 words.
- Backpressure: first=last=5, reg5=32'hDEAD_BEEF, out_ready low for 7 cycles.
  - Expect out_valid and out_data stable throughout, a single transfer, then the done pulse.
  - Expect checksum=32'hDEAD_BEEF.
- Abort: abort asserted in SEND of the 3rd word of a 0..31 dump.
  - Expect IDLE next cycle, out_valid=0, no done, busy=0.
  - Expect checksum = XOR of the first 2 words.
  - Then start with first=last=7 and expect exactly one word.
- Start while busy: pulse start with new first/last mid-dump.
  - Expect the original range completes unchanged and no second dump.
- Reset mid-dump: resetn low during LOAD.
  - Expect all outputs at reset values immediately, and a clean new dump after release.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - output word stream of the register-file dump reader
// Ports: out_valid/out_ready handshake carrying out_data, out_index, out_last.
// master drives the word, slave returns out_ready.
interface regfile_dump_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register index range and streams each word out
// Ports: clk/resetn (async active-low); start/first_idx/last_idx/abort control;
// rf_raddr/rf_rdata debug read port; out_if word stream; busy, done pulse,
// checksum (XOR of accepted words of the current or most recent dump).
module regfile_dump_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     first_idx,
    input  logic [ADDR_W-1:0]     last_idx,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     rf_raddr,
    input  logic [DATA_W-1:0]     rf_rdata,
    regfile_dump_reader_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              olast_q, olast_d;
    logic [DATA_W-1:0] cks_q, cks_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            olast_q <= 1'b0;
            cks_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
            index_q <= index_d;
            olast_q <= olast_d;
            cks_q   <= cks_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        data_d  = data_q;
        index_d = index_q;
        olast_d = olast_q;
        cks_d   = cks_q;

        case (state_q)
            IDLE: begin
                // abort in IDLE only suppresses a coincident start
                if (start && !abort) begin
                    idx_d   = first_idx;
                    last_d  = last_idx;
                    cks_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    data_d  = rf_rdata;
                    index_d = idx_q;
                    olast_d = (idx_q == last_q);
                    state_d = SEND;
                end
            end
            SEND: begin
                // abort wins over a simultaneous handshake: the word is not counted
                if (abort) begin
                    state_d = IDLE;
                end else if (out_if.out_ready) begin
                    cks_d = cks_q ^ data_q;
                    if (olast_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The read port always points at the current index; reads have no side effects.
    assign rf_raddr         = idx_q;
    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = data_q;
    assign out_if.out_index = index_q;
    assign out_if.out_last  = olast_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign checksum         = cks_q;

endmodule
